// File: rtl/step_pkg.sv
// -----------------------------------------------------------------------------
// step_pkg
// Shared definitions for the step/direction decoder:
//   - default MIN_WIDTH / MAX_WIDTH / CNT_W parameter values
//   - WIDTH_W, width of the pulse-width counter and WIDTH output
//   - state_e, the decoder FSM state encoding (IDLE / MEASURE / HOLD)
//   - sat_inc(), saturating increment for the width counter
// -----------------------------------------------------------------------------
package step_pkg;

    localparam int DEF_MIN_WIDTH = 4;
    localparam int DEF_MAX_WIDTH = 16;
    localparam int DEF_CNT_W     = 16;
    localparam int WIDTH_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    // Width counter sticks at all-ones so WIDTH reports min(count, 255).
    function automatic logic [WIDTH_W-1:0] sat_inc(input logic [WIDTH_W-1:0] v);
        return (v == {WIDTH_W{1'b1}}) ? v : v + WIDTH_W'(1);
    endfunction

endpackage

// File: rtl/step_sync.sv
// -----------------------------------------------------------------------------
// step_sync
// Brings one asynchronous input into the CLK domain and detects its rising
// edge.
//   CLK       in   system clock, rising edge
//   RSTn      in   asynchronous active-low reset
//   async_in  in   asynchronous input pin
//   level     out  synchronized (and optionally filtered) level
//   rise      out  single-cycle rising-edge strobe on level
// Build option: STEP_DEC_FILTER_EN adds a 3-sample consistency filter after
// the 2-FF synchronizer (adds 2 cycles of latency, drops pulses of <= 2
// cycles).
// -----------------------------------------------------------------------------
module step_sync
    import step_pkg::*;
(
    input  logic CLK,
    input  logic RSTn,
    input  logic async_in,
    output logic level,
    output logic rise
);

`ifdef STEP_DEC_FILTER_EN
    // Synchronizer plus filter history must be filled before level is real.
    localparam int PRIME_N = 4;
`else
    localparam int PRIME_N = 2;
`endif

    logic               meta_q;
    logic               sync_q;
    logic               prev_q;
    logic               armed_q;
    logic               armed_d;
    logic [PRIME_N-1:0] prime_q;
    logic [PRIME_N-1:0] prime_d;

`ifdef STEP_DEC_FILTER_EN
    logic [1:0] hist_q;
    logic [1:0] hist_d;
    logic       filt_q;
    logic       filt_d;

    // Level follows the input only once three consecutive samples agree.
    always_comb begin
        hist_d = {hist_q[0], sync_q};
        filt_d = filt_q;
        if ((sync_q == hist_q[0]) && (hist_q[0] == hist_q[1])) begin
            filt_d = sync_q;
        end
    end

    assign level = filt_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end
`else
    assign level = sync_q;
`endif

    // The reset value of the pipeline is not a real sample of the pin: an
    // input already high at reset release must not look like a fresh edge.
    // prime_q marks when level reflects the pin; edges are accepted only
    // after a genuine low has been observed.
    always_comb begin
        prime_d = {prime_q[PRIME_N-2:0], 1'b1};
        armed_d = armed_q | (prime_q[PRIME_N-1] & ~level);
    end

    assign rise = armed_q & level & ~prev_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            prime_q <= '0;
        end else begin
            meta_q  <= async_in;
            sync_q  <= meta_q;
            prev_q  <= level;
            armed_q <= armed_d;
            prime_q <= prime_d;
        end
    end

endmodule

// File: rtl/step_decoder.sv
// -----------------------------------------------------------------------------
// step_decoder
// Decodes an asynchronous STEP/DIR interface into a signed position count,
// validating each STEP pulse's high time against [MIN_WIDTH, MAX_WIDTH].
//   CLK         in   system clock, rising edge
//   RSTn        in   asynchronous active-low reset
//   STEP        in   asynchronous step pulse, active high
//   DIR         in   asynchronous direction, 1 = up, 0 = down
//   CLR         in   synchronous clear of POS, ERR_SHORT and ERR_LONG
//   POS         out  signed position, wraps modulo 2^CNT_W
//   STEP_VALID  out  one-cycle strobe per accepted step
//   WIDTH       out  high time of last completed pulse, saturating at 255
//   ERR_SHORT   out  sticky: a pulse was shorter than MIN_WIDTH
//   ERR_LONG    out  sticky: a pulse was longer than MAX_WIDTH
//   BUSY        out  FSM not idle
// Build option: STEP_DEC_FILTER_EN enables the input glitch filter inside
// step_sync. MAX_WIDTH must be below 255 so the HOLD threshold is reachable
// by the saturating width counter.
// -----------------------------------------------------------------------------
module step_decoder
    import step_pkg::*;
#(
    parameter int MIN_WIDTH = DEF_MIN_WIDTH,
    parameter int MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    STEP,
    input  logic                    DIR,
    input  logic                    CLR,
    output logic signed [CNT_W-1:0] POS,
    output logic                    STEP_VALID,
    output logic [WIDTH_W-1:0]      WIDTH,
    output logic                    ERR_SHORT,
    output logic                    ERR_LONG,
    output logic                    BUSY
);

    logic step_lvl;
    logic step_rise;
    logic dir_lvl;
    logic dir_rise_unused;

    step_sync u_step_sync (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .async_in (STEP),
        .level    (step_lvl),
        .rise     (step_rise)
    );

    step_sync u_dir_sync (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .async_in (DIR),
        .level    (dir_lvl),
        .rise     (dir_rise_unused)
    );

    state_e             state_q,     state_d;
    logic [WIDTH_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH_W-1:0] width_q,     width_d;
    logic [CNT_W-1:0]   pos_q,       pos_d;
    logic               dir_lat_q,   dir_lat_d;
    logic               valid_q,     valid_d;
    logic               err_short_q, err_short_d;
    logic               err_long_q,  err_long_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        width_d     = width_q;
        pos_d       = pos_q;
        dir_lat_d   = dir_lat_q;
        valid_d     = 1'b0;
        err_short_d = err_short_q;
        err_long_d  = err_long_q;

        case (state_q)
            ST_IDLE: begin
                if (step_rise) begin
                    state_d   = ST_MEASURE;
                    cnt_d     = WIDTH_W'(1);
                    dir_lat_d = dir_lvl;
                end
            end
            ST_MEASURE: begin
                if (step_lvl) begin
                    cnt_d = sat_inc(cnt_q);
                    // Count is about to become MAX_WIDTH+1: pulse is too long.
                    if (cnt_q == WIDTH_W'(MAX_WIDTH)) begin
                        state_d    = ST_HOLD;
                        err_long_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    width_d = cnt_q;
                    if (cnt_q >= WIDTH_W'(MIN_WIDTH)) begin
                        valid_d = 1'b1;
                        pos_d   = dir_lat_q ? (pos_q + CNT_W'(1))
                                            : (pos_q - CNT_W'(1));
                    end else begin
                        err_short_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // Keep counting so WIDTH reports the full (saturated) length.
                if (step_lvl) begin
                    cnt_d = sat_inc(cnt_q);
                end else begin
                    state_d = ST_IDLE;
                    width_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear overrides a same-cycle step or error; STEP_VALID still fires.
        if (CLR) begin
            pos_d       = '0;
            err_short_d = 1'b0;
            err_long_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            width_q     <= '0;
            pos_q       <= '0;
            dir_lat_q   <= 1'b0;
            valid_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            width_q     <= width_d;
            pos_q       <= pos_d;
            dir_lat_q   <= dir_lat_d;
            valid_q     <= valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign POS        = pos_q;
    assign STEP_VALID = valid_q;
    assign WIDTH      = width_q;
    assign ERR_SHORT  = err_short_q;
    assign ERR_LONG   = err_long_q;
    assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_step_decoder
// Scoreboard bench: each STEP pulse pushes its expected outcome when STEP is
// released; a monitor pops and compares when BUSY drops. Position counter is
// built 8 bits wide so the signed wrap boundary is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_step_decoder;

    localparam int MIN_W = 4;
    localparam int MAX_W = 16;
    localparam int CW    = 8;
`ifdef STEP_DEC_FILTER_EN
    localparam int LAT     = 5;
    localparam int FILT_ON = 1;
`else
    localparam int LAT     = 3;
    localparam int FILT_ON = 0;
`endif

    logic          CLK;
    logic          RSTn;
    logic          STEP;
    logic          DIR;
    logic          CLR;
    logic [CW-1:0] POS;
    logic          STEP_VALID;
    logic [7:0]    WIDTH;
    logic          ERR_SHORT;
    logic          ERR_LONG;
    logic          BUSY;

    step_decoder #(
        .MIN_WIDTH (MIN_W),
        .MAX_WIDTH (MAX_W),
        .CNT_W     (CW)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .STEP       (STEP),
        .DIR        (DIR),
        .CLR        (CLR),
        .POS        (POS),
        .STEP_VALID (STEP_VALID),
        .WIDTH      (WIDTH),
        .ERR_SHORT  (ERR_SHORT),
        .ERR_LONG   (ERR_LONG),
        .BUSY       (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    typedef struct {
        int         n;
        bit         valid;
        logic [7:0] pos;
        logic [7:0] width;
        bit         es;
        bit         el;
        int         fall_cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         n_valid_seen = 0;
    int         busy_cnt = 0;
    int         n_txn    = 0;
    bit         mon_en   = 1'b0;

    // Reference model state
    logic [7:0] m_pos   = 8'h00;
    logic [7:0] m_width = 8'h00;
    bit         m_es    = 1'b0;
    bit         m_el    = 1'b0;
    int         m_valid = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: outputs settle in the cycle BUSY drops after a pulse.
    initial begin : monitor
        exp_t e;
        logic busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (STEP_VALID === 1'b1) n_valid_seen++;
            if (BUSY === 1'b1) busy_cnt++;
            if (mon_en && busy_prev && (BUSY === 1'b0)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_txn", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    n_txn++;
                    $display("txn %0d: n=%0d valid=%0b pos=%02h width=%0d es=%0b el=%0b lat=%0d",
                             n_txn, e.n, STEP_VALID, POS, WIDTH, ERR_SHORT, ERR_LONG,
                             cyc - e.fall_cyc);
                    chk("step_valid", STEP_VALID, e.valid);
                    chk("pos",        POS,        e.pos);
                    chk("width",      WIDTH,      e.width);
                    chk("err_short",  ERR_SHORT,  e.es);
                    chk("err_long",   ERR_LONG,   e.el);
                    chk("latency",    cyc - e.fall_cyc, LAT);
                end
            end
            busy_prev = BUSY;
        end
    end

    task automatic pulse(input int n, input bit dir, input bit flip_dir, input bit clr_acc);
        exp_t e;
        bit   ok;
        bit   ign;
        bit   watch_long;
        ign        = (FILT_ON != 0) && (n <= 2);
        watch_long = (n > MAX_W) && (LAT + MAX_W <= n) && !m_el;
        DIR  = dir;
        STEP = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge CLK);
            if (flip_dir && i == n / 2) DIR = ~dir;
            if (watch_long && i == LAT + MAX_W - 1) chk("err_long_before_hold", ERR_LONG, 1'b0);
            if (watch_long && i == LAT + MAX_W) begin
                chk("err_long_at_hold", ERR_LONG, 1'b1);
                chk("busy_in_hold", BUSY, 1'b1);
            end
        end
        STEP = 1'b0;
        if (!ign) begin
            ok = (n >= MIN_W) && (n <= MAX_W);
            if (ok) begin
                m_pos = dir ? (m_pos + 8'd1) : (m_pos - 8'd1);
                m_valid++;
            end
            if (n < MIN_W) m_es = 1'b1;
            if (n > MAX_W) m_el = 1'b1;
            if (clr_acc) begin
                m_pos = 8'h00;
                m_es  = 1'b0;
                m_el  = 1'b0;
            end
            m_width    = (n > 255) ? 8'd255 : 8'(n);
            e.n        = n;
            e.valid    = ok;
            e.pos      = m_pos;
            e.width    = m_width;
            e.es       = m_es;
            e.el       = m_el;
            e.fall_cyc = cyc;
            exp_q.push_back(e);
        end
        if (clr_acc) begin
            repeat (LAT - 1) @(negedge CLK);
            CLR = 1'b1;
            @(negedge CLK);
            CLR = 1'b0;
            repeat (6) @(negedge CLK);
        end else begin
            repeat (LAT + 5) @(negedge CLK);
        end
    endtask

    task automatic clr_idle();
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        m_pos = 8'h00;
        m_es  = 1'b0;
        m_el  = 1'b0;
        chk("clr_pos",       POS,       8'h00);
        chk("clr_err_short", ERR_SHORT, 1'b0);
        chk("clr_err_long",  ERR_LONG,  1'b0);
        chk("clr_width",     WIDTH,     m_width);
    endtask

    initial begin : main
        int b0;
        RSTn = 1'b0;
        STEP = 1'b0;
        DIR  = 1'b0;
        CLR  = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_pos",        POS,        8'h00);
        chk("rst_width",      WIDTH,      8'h00);
        chk("rst_step_valid", STEP_VALID, 1'b0);
        chk("rst_err_short",  ERR_SHORT,  1'b0);
        chk("rst_err_long",   ERR_LONG,   1'b0);
        chk("rst_busy",       BUSY,       1'b0);
        RSTn = 1'b1;
        repeat (6) @(negedge CLK);
        mon_en = 1'b1;

        pulse(6, 1'b1, 1'b0, 1'b0);      // basic up step
        pulse(3, 1'b1, 1'b0, 1'b0);      // too short
        pulse(6, 1'b1, 1'b0, 1'b0);      // still counts, ERR_SHORT sticky
        pulse(20, 1'b1, 1'b0, 1'b0);     // too long, HOLD at count 17
        clr_idle();
        pulse(300, 1'b1, 1'b0, 1'b0);    // WIDTH saturates
        pulse(8, 1'b1, 1'b1, 1'b0);      // DIR flipped mid-pulse
        clr_idle();
        pulse(5, 1'b0, 1'b0, 1'b0);      // 0x00 - 1 -> 0xFF
        for (int k = 0; k < 128; k++) begin
            pulse(int'($urandom_range(MIN_W, MAX_W)), 1'b1, 1'b0, 1'b0);
        end
        pulse(MIN_W, 1'b1, 1'b0, 1'b0);  // 0x7F + 1 -> 0x80
        pulse(MAX_W, 1'b1, 1'b0, 1'b0);  // longest legal pulse
        pulse(MAX_W + 1, 1'b1, 1'b0, 1'b0);  // shortest illegal long pulse
        pulse(MIN_W - 1, 1'b0, 1'b0, 1'b0);  // longest illegal short pulse
        pulse(6, 1'b1, 1'b0, 1'b1);      // CLR coincident with acceptance

        b0 = busy_cnt;
        pulse(2, 1'b1, 1'b0, 1'b0);      // glitch: filtered out when enabled
`ifdef STEP_DEC_FILTER_EN
        chk("glitch_busy_cycles", busy_cnt - b0, 0);
        chk("glitch_err_short",   ERR_SHORT, 1'b0);
`endif
        chk("after_glitch_pos", POS, m_pos);

        // Reset in the middle of a pulse; STEP stays high past release.
        STEP = 1'b1;
        DIR  = 1'b1;
        repeat (8) @(negedge CLK);
        chk("busy_before_rst", BUSY, 1'b1);
        mon_en = 1'b0;
        RSTn = 1'b0;
        #2;
        chk("midrst_pos",        POS,        8'h00);
        chk("midrst_width",      WIDTH,      8'h00);
        chk("midrst_step_valid", STEP_VALID, 1'b0);
        chk("midrst_err_short",  ERR_SHORT,  1'b0);
        chk("midrst_err_long",   ERR_LONG,   1'b0);
        chk("midrst_busy",       BUSY,       1'b0);
        @(negedge CLK);
        RSTn = 1'b1;
        m_pos = 8'h00; m_es = 1'b0; m_el = 1'b0; m_width = 8'h00;
        b0 = busy_cnt;
        repeat (10) @(negedge CLK);
        STEP = 1'b0;
        repeat (LAT + 6) @(negedge CLK);
        chk("held_step_ignored_busy", busy_cnt - b0, 0);
        chk("held_step_ignored_pos",  POS,   8'h00);
        chk("held_step_width",        WIDTH, 8'h00);
        mon_en = 1'b1;

        pulse(6, 1'b1, 1'b0, 1'b0);      // decoder armed again after reset

        repeat (10) @(negedge CLK);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("step_valid_count", n_valid_seen, m_valid);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
